// File: rtl/nested_sys_reg_file_if.sv
// Register-file bus for nested_sys_reg_file: software register access, interrupt
// request/return controls, and the vectoring/status outputs back to the core.
interface nested_sys_reg_file_if #(
  parameter int DBITS      = 32,
  parameter int NUM_IRQ    = 4,
  parameter int NEST_DEPTH = 4
) ();
  localparam int LVL_W = $clog2(NEST_DEPTH + 1);

  logic                sysWrtEn;
  logic [3:0]          wrtIndex;
  logic [3:0]          rdIndex;
  logic [DBITS-1:0]    dataIn;
  logic [DBITS-1:0]    pcIn;
  logic [NUM_IRQ-1:0]  irq;
  logic                isReti;
  logic                intAck;
  logic [DBITS-1:0]    intVec;
  logic [DBITS-1:0]    dataOut;
  logic [LVL_W-1:0]    nestLevel;
  logic [DBITS-1:0]    debugSysOut;

  modport master (
    output sysWrtEn, wrtIndex, rdIndex, dataIn, pcIn, irq, isReti,
    input  intAck, intVec, dataOut, nestLevel, debugSysOut
  );

  modport slave (
    input  sysWrtEn, wrtIndex, rdIndex, dataIn, pcIn, irq, isReti,
    output intAck, intVec, dataOut, nestLevel, debugSysOut
  );
endinterface

// File: rtl/nested_sys_reg_file.sv
// System register file with nested interrupt support: a frame stack saves PCS/IRA
// on every taken interrupt and restores them on RETI.
module nested_sys_reg_file #(
  parameter int DBITS      = 32,
  parameter int NUM_IRQ    = 4,
  parameter int NEST_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  nested_sys_reg_file_if.slave  bus
);
  localparam int LVL_W = $clog2(NEST_DEPTH + 1);

  localparam logic [3:0] IDX_PCS = 4'd0;
  localparam logic [3:0] IDX_IHA = 4'd1;
  localparam logic [3:0] IDX_IRA = 4'd2;
  localparam logic [3:0] IDX_IDN = 4'd3;
  localparam logic [3:0] IDX_IMR = 4'd4;
  localparam logic [3:0] IDX_ISR = 4'd5;

  logic [DBITS-1:0]   pcs, iha, ira, idn, imr;
  logic [LVL_W-1:0]   nestLevel;
  logic               nestErr;

  // One slot more than NEST_DEPTH so nestLevel indexes the stack at its natural width;
  // the top slot is never written.
  logic [DBITS-1:0]   stackPcs [NEST_DEPTH+1];
  logic [DBITS-1:0]   stackIra [NEST_DEPTH+1];

  logic [NUM_IRQ-1:0] pending;
  logic [3:0]         selIdx;
  logic               anyPending, atDepth, take, retiPop, retiErr, depthErr;
  logic [LVL_W-1:0]   popIdx;
  logic [DBITS-1:0]   isrVal, regRead;
  logic               bypass;

  always_comb begin
    pending = bus.irq & imr[NUM_IRQ-1:0];
    selIdx  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) selIdx = 4'(i);
    end
  end

  assign anyPending = |pending;
  assign atDepth    = (nestLevel == LVL_W'(NEST_DEPTH));
  assign take       = pcs[0] & anyPending & ~bus.isReti & ~atDepth;
  assign depthErr   = pcs[0] & anyPending & ~bus.isReti & atDepth;
  assign retiPop    = bus.isReti & (nestLevel != '0);
  assign retiErr    = bus.isReti & (nestLevel == '0);
  assign popIdx     = nestLevel - LVL_W'(1);

  always_ff @(posedge clk) begin
    if (take) begin
      stackPcs[nestLevel] <= pcs;
      stackIra[nestLevel] <= ira;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcs       <= '0;
      iha       <= '0;
      ira       <= '0;
      idn       <= '0;
      imr       <= '0;
      nestLevel <= '0;
      nestErr   <= 1'b0;
    end else begin
      // Any RETI, even an erroneous one, owns PCS/IRA/IDN for the cycle.
      if (take) begin
        pcs       <= '0;
        ira       <= bus.pcIn;
        idn       <= DBITS'(selIdx);
        nestLevel <= nestLevel + LVL_W'(1);
      end else if (retiPop) begin
        pcs       <= stackPcs[popIdx];
        ira       <= stackIra[popIdx];
        nestLevel <= popIdx;
      end else if (!bus.isReti && bus.sysWrtEn) begin
        case (bus.wrtIndex)
          IDX_PCS: pcs <= bus.dataIn;
          IDX_IRA: ira <= bus.dataIn;
          IDX_IDN: idn <= bus.dataIn;
          default: ;
        endcase
      end

      if (bus.sysWrtEn && bus.wrtIndex == IDX_IHA) iha <= bus.dataIn;
      if (bus.sysWrtEn && bus.wrtIndex == IDX_IMR) imr <= bus.dataIn;

      // A fresh error in the same cycle as the clearing write wins.
      if (bus.sysWrtEn && bus.wrtIndex == IDX_ISR) nestErr <= 1'b0;
      if (retiErr || depthErr) nestErr <= 1'b1;
    end
  end

  always_comb begin
    isrVal              = '0;
    isrVal[NUM_IRQ-1:0] = pending;
    isrVal[DBITS-1]     = nestErr;
    case (bus.rdIndex)
      IDX_PCS: regRead = pcs;
      IDX_IHA: regRead = iha;
      IDX_IRA: regRead = ira;
      IDX_IDN: regRead = idn;
      IDX_IMR: regRead = imr;
      IDX_ISR: regRead = isrVal;
      default: regRead = '0;
    endcase
  end

  assign bypass = bus.sysWrtEn && (bus.wrtIndex == bus.rdIndex) && (bus.rdIndex <= IDX_IMR);

  assign bus.dataOut     = bypass ? bus.dataIn : regRead;
  assign bus.intAck      = take;
  assign bus.intVec      = take ? iha : ira;
  assign bus.nestLevel   = nestLevel;
  assign bus.debugSysOut = pcs;
endmodule

// File: tb/tb_nested_sys_reg_file.sv
// Scoreboard bench for nested_sys_reg_file: stimulus queues expected output values,
// a negedge monitor pops and compares them against the DUT.
module tb_nested_sys_reg_file;
  localparam int DBITS = 32;
  localparam int NIRQ  = 4;
  localparam int DEPTH = 2;

  localparam int S_ACK = 0;
  localparam int S_VEC = 1;
  localparam int S_DOUT = 2;
  localparam int S_LVL = 3;
  localparam int S_DBG = 4;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  chk_t expQ[$];

  always #5 clk = ~clk;

  nested_sys_reg_file_if #(.DBITS(DBITS), .NUM_IRQ(NIRQ), .NEST_DEPTH(DEPTH)) bus ();

  nested_sys_reg_file #(.DBITS(DBITS), .NUM_IRQ(NIRQ), .NEST_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_ACK:   return {31'b0, bus.intAck};
      S_VEC:   return bus.intVec;
      S_DOUT:  return bus.dataOut;
      S_LVL:   return 32'(bus.nestLevel);
      default: return bus.debugSysOut;
    endcase
  endfunction

  task automatic want(input string nm, input int sel, input logic [31:0] v);
    chk_t c;
    c.name = nm;
    c.sel  = sel;
    c.exp  = v;
    expQ.push_back(c);
  endtask

  always @(negedge clk) begin : monitor
    chk_t c;
    logic [31:0] act;
    while (expQ.size() > 0) begin
      c   = expQ.pop_front();
      act = actual(c.sel);
      checks++;
      if (act !== c.exp) begin
        failures++;
        $display("FAIL %s actual=0x%0h required=0x%0h", c.name, act, c.exp);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] idx, input logic [31:0] val);
    bus.sysWrtEn = 1'b1;
    bus.wrtIndex = idx;
    bus.dataIn   = val;
    cyc();
    bus.sysWrtEn = 1'b0;
  endtask

  initial begin
    int waited;
    reset = 1'b0;
    bus.sysWrtEn = 1'b0;
    bus.wrtIndex = '0;
    bus.rdIndex  = '0;
    bus.dataIn   = '0;
    bus.pcIn     = '0;
    bus.irq      = '0;
    bus.isReti   = 1'b0;
    cyc();
    cyc();

    bus.rdIndex = 4'd4;
    want("rst_ack", S_ACK, 0);
    want("rst_lvl", S_LVL, 0);
    want("rst_pcs", S_DBG, 0);
    want("rst_imr", S_DOUT, 0);
    want("rst_vec", S_VEC, 0);
    cyc();
    reset = 1'b1;
    cyc();

    bus.sysWrtEn = 1'b1; bus.wrtIndex = 4'd1; bus.dataIn = 32'h100; bus.rdIndex = 4'd1;
    want("bypass_iha", S_DOUT, 32'h100);
    cyc();
    wr(4'd4, 32'hF);
    wr(4'd0, 32'h1);

    // First interrupt: irq[2:1] pending, lowest index 1 wins
    bus.irq = 4'b0110; bus.pcIn = 32'h40; bus.rdIndex = 4'd2;
    want("take1_ack", S_ACK, 1);
    want("take1_vec", S_VEC, 32'h100);
    want("take1_ira_pre", S_DOUT, 0);
    cyc();
    bus.irq = '0; bus.rdIndex = 4'd3;
    want("h1_lvl", S_LVL, 1);
    want("h1_pcs", S_DBG, 0);
    want("h1_ira", S_VEC, 32'h40);
    want("h1_ack", S_ACK, 0);
    want("h1_idn", S_DOUT, 1);
    cyc();

    // Nested interrupt after software IE re-enable
    wr(4'd0, 32'h1);
    bus.irq = 4'b0001; bus.pcIn = 32'h108;
    want("take2_ack", S_ACK, 1);
    want("take2_vec", S_VEC, 32'h100);
    cyc();
    bus.irq = '0; bus.rdIndex = 4'd3;
    want("h2_lvl", S_LVL, 2);
    want("h2_ira", S_VEC, 32'h108);
    want("h2_pcs", S_DBG, 0);
    want("h2_idn", S_DOUT, 0);
    cyc();

    // Depth exhausted: request stays pending, nestErr raised
    wr(4'd0, 32'h1);
    bus.irq = 4'b0001; bus.rdIndex = 4'd5;
    want("full_ack", S_ACK, 0);
    want("full_isr_pre", S_DOUT, 32'h1);
    want("full_lvl", S_LVL, 2);
    cyc();
    want("full_isr_err", S_DOUT, 32'h8000_0001);
    want("full_ack2", S_ACK, 0);
    cyc();
    bus.irq = '0; bus.sysWrtEn = 1'b1; bus.wrtIndex = 4'd5; bus.dataIn = 32'hFFFF_FFFF;
    want("isr_no_bypass", S_DOUT, 32'h8000_0000);
    cyc();
    bus.sysWrtEn = 1'b0;
    want("isr_cleared", S_DOUT, 0);
    cyc();

    bus.isReti = 1'b1;
    want("reti1_ack", S_ACK, 0);
    want("reti1_vec", S_VEC, 32'h108);
    cyc();
    bus.isReti = 1'b0;
    want("reti1_lvl", S_LVL, 1);
    want("reti1_ira", S_VEC, 32'h40);
    cyc();

    // RETI and a would-be take together: RETI only, take next cycle
    bus.isReti = 1'b1; bus.irq = 4'b1000;
    want("reti_take_ack", S_ACK, 0);
    cyc();
    bus.isReti = 1'b0;
    want("retake_lvl", S_LVL, 0);
    want("retake_pcs", S_DBG, 1);
    want("retake_ack", S_ACK, 1);
    want("retake_vec", S_VEC, 32'h100);
    cyc();
    bus.irq = '0; bus.rdIndex = 4'd3;
    want("h3_lvl", S_LVL, 1);
    want("h3_pcs", S_DBG, 0);
    want("h3_idn", S_DOUT, 3);
    want("h3_ira", S_VEC, 32'h108);
    cyc();

    // Software writes colliding with RETI
    bus.isReti = 1'b1; bus.sysWrtEn = 1'b1; bus.wrtIndex = 4'd2; bus.dataIn = 32'hDEAD;
    cyc();
    bus.isReti = 1'b0; bus.sysWrtEn = 1'b0; bus.rdIndex = 4'd2;
    want("reti_wr_lvl", S_LVL, 0);
    want("reti_wr_pcs", S_DBG, 1);
    want("reti_wr_ira", S_DOUT, 0);
    cyc();
    bus.isReti = 1'b1; bus.sysWrtEn = 1'b1; bus.wrtIndex = 4'd1; bus.dataIn = 32'h300;
    cyc();
    bus.isReti = 1'b0; bus.sysWrtEn = 1'b0; bus.rdIndex = 4'd1;
    want("reti0_iha", S_DOUT, 32'h300);
    want("reti0_lvl", S_LVL, 0);
    want("reti0_pcs", S_DBG, 1);
    cyc();
    bus.rdIndex = 4'd5;
    want("reti0_err", S_DOUT, 32'h8000_0000);
    cyc();

    wr(4'd5, 32'h0);
    wr(4'd0, 32'h0);
    wr(4'd4, 32'h3);
    bus.irq = 4'b0101; bus.rdIndex = 4'd5;
    want("isr_pending", S_DOUT, 32'h1);
    want("ie_off_ack", S_ACK, 0);
    cyc();
    bus.sysWrtEn = 1'b1; bus.wrtIndex = 4'd1; bus.rdIndex = 4'd1; bus.dataIn = 32'h200;
    want("bypass_200", S_DOUT, 32'h200);
    cyc();
    bus.wrtIndex = 4'd9; bus.rdIndex = 4'd9; bus.dataIn = 32'h55;
    want("idx9_read", S_DOUT, 0);
    cyc();
    bus.sysWrtEn = 1'b0; bus.rdIndex = 4'd1;
    want("iha_200", S_DOUT, 32'h200);
    cyc();

    // Reset while two frames deep
    bus.irq = '0;
    wr(4'd4, 32'hF);
    wr(4'd0, 32'h1);
    bus.irq = 4'b0010; bus.pcIn = 32'h500;
    cyc();
    bus.irq = '0;
    wr(4'd0, 32'h1);
    bus.irq = 4'b0010;
    cyc();
    bus.irq = '0; bus.rdIndex = 4'd1;
    want("pre_rst_lvl", S_LVL, 2);
    cyc();
    reset = 1'b0;
    want("arst_lvl", S_LVL, 0);
    want("arst_pcs", S_DBG, 0);
    want("arst_vec", S_VEC, 0);
    want("arst_ack", S_ACK, 0);
    want("arst_iha", S_DOUT, 0);
    cyc();
    reset = 1'b1; bus.irq = 4'b0001; bus.rdIndex = 4'd4;
    want("post_rst_ack", S_ACK, 0);
    want("post_rst_imr", S_DOUT, 0);
    want("post_rst_lvl", S_LVL, 0);
    cyc();

    waited = 0;
    while (expQ.size() > 0 && waited < 10) begin
      cyc();
      waited++;
    end
    if (expQ.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t required=finish", $time);
    $fatal(1, "watchdog");
  end
endmodule
